ghostbus_arb: RTL and testbench

GHOSTBUS_ARB -- requirements
Module: ghostbus_arb

---
 rtl/ghostbus_arb.sv | 141 ++++++++++++++
 tb/tb_ghostbus_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_arb.sv
// ghostbus_arb: two-master round-robin arbiter in front of a fixed-latency ghostbus.
//
// Handshake: a master raises req with addr/wdata/we stable and holds req until
// it sees its one-cycle ack. The arbiter copies the winner's fields when it
// grants, so anything the master does to them after the grant is ignored.
// Read data appears on the owner's rdata in the same cycle as its ack.
//
// Every output is a register. o_dbg_state mirrors the FSM:
// 0 = IDLE, 1 = ISSUE, 2 = WAIT, 3 = DONE.
module ghostbus_arb #(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int RL = 1     // ghostbus read latency, legal range 1..8
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    gnt,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    input  logic [DW-1:0] gb_din,
    output logic [1:0]    o_dbg_state
);

    localparam int CW = $clog2(RL + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_owner;     // 0 = m0, 1 = m1
    logic          r_last_m1;   // 1 when m1 was granted most recently
    logic [1:0]    r_mask;      // acks seen in the previous cycle, {m1, m0}
    logic          r_we;
    logic [CW-1:0] r_cnt;

    logic w_elig0;
    logic w_elig1;
    logic w_pick_m1;
    logic w_any;

    // A requester acked in the previous cycle sits out one arbitration; on a
    // tie the requester that was not granted last wins.
    assign w_elig0   = m0_req & ~r_mask[0];
    assign w_elig1   = m1_req & ~r_mask[1];
    assign w_any     = w_elig0 | w_elig1;
    assign w_pick_m1 = w_elig1 & (~w_elig0 | ~r_last_m1);

    assign o_dbg_state = r_state;

    // Transaction FSM: grant, drive the bus, wait out the read latency, ack.
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last_m1 <= 1'b1;      // m0 wins the first tie after reset
            r_mask    <= 2'b00;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            gnt       <= 2'b00;
            gb_addr   <= '0;
            gb_dout   <= '0;
            gb_we     <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            r_mask <= {m1_ack, m0_ack};
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_pick_m1;
                        r_last_m1 <= w_pick_m1;
                        gnt       <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_we      <= w_pick_m1 ? m1_we : m0_we;
                        gb_we     <= w_pick_m1 ? m1_we : m0_we;
                        gb_addr   <= w_pick_m1 ? m1_addr : m0_addr;
                        gb_dout   <= w_pick_m1 ? m1_wdata : m0_wdata;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    gb_we   <= 1'b0;
                    gb_dout <= '0;
                    if (r_we) begin
                        gb_addr <= '0;
                        m0_ack  <= ~r_owner;
                        m1_ack  <= r_owner;
                        r_state <= S_DONE;
                    end else begin
                        // address stays on the bus while the read data arrives
                        r_cnt   <= CW'(RL);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CW'(1)) begin
                        if (r_owner) begin
                            m1_rdata <= gb_din;
                        end else begin
                            m0_rdata <= gb_din;
                        end
                        gb_addr <= '0;
                        m0_ack  <= ~r_owner;
                        m1_ack  <= r_owner;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    gnt     <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghostbus_arb.sv
// tb_ghostbus_arb: three arbiters (RL = 1, 3, 4) driven side by side. A
// transaction-level model schedules each granted transaction as a window of
// cycles (issue, wait, ack) and every cycle the DUT outputs are compared to
// what that window says they must be. Directed sequences pin the model with
// hand-computed cycle offsets and values.
`timescale 1ns/1ps
module tb_ghostbus_arb;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NI = 3;

    function automatic int rl_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_a   [NI];
    logic          req_a   [NI][2];
    logic [AW-1:0] addr_a  [NI][2];
    logic [DW-1:0] wdata_a [NI][2];
    logic          we_a    [NI][2];
    logic          ack_a   [NI][2];
    logic [DW-1:0] rdata_a [NI][2];
    logic [1:0]    gnt_a   [NI];
    logic [AW-1:0] gba_a   [NI];
    logic [DW-1:0] gbo_a   [NI];
    logic          gbwe_a  [NI];
    logic [DW-1:0] gbi_a   [NI];
    logic [1:0]    st_a    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ghostbus_arb #(.AW(AW), .DW(DW), .RL(rl_of(g))) u_dut (
            .gb_clk      (clk),
            .gb_rst      (rst_a[g]),
            .m0_req      (req_a[g][0]),
            .m0_addr     (addr_a[g][0]),
            .m0_wdata    (wdata_a[g][0]),
            .m0_we       (we_a[g][0]),
            .m0_ack      (ack_a[g][0]),
            .m0_rdata    (rdata_a[g][0]),
            .m1_req      (req_a[g][1]),
            .m1_addr     (addr_a[g][1]),
            .m1_wdata    (wdata_a[g][1]),
            .m1_we       (we_a[g][1]),
            .m1_ack      (ack_a[g][1]),
            .m1_rdata    (rdata_a[g][1]),
            .gnt         (gnt_a[g]),
            .gb_addr     (gba_a[g]),
            .gb_dout     (gbo_a[g]),
            .gb_we       (gbwe_a[g]),
            .gb_din      (gbi_a[g]),
            .o_dbg_state (st_a[g])
        );
    end

    // ---------------- scoreboard state ----------------
    int n_pass  = 0;
    int n_total = 0;
    bit sim_done = 1'b0;

    // one scheduled transaction per instance
    bit            m_ok   [NI];
    bit            mv     [NI];
    longint        m_iss  [NI];
    longint        m_ack  [NI];
    longint        m_nidle[NI];
    int            m_own  [NI];
    int            m_last [NI];
    bit            m_we   [NI];
    logic [AW-1:0] m_addr [NI];
    logic [DW-1:0] m_wd   [NI];
    logic [DW-1:0] m_rv   [NI];
    logic [DW-1:0] m_rd   [NI][2];
    bit            use_42 [NI];

    function automatic void chk(input string name, input int inst,
                                input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h",
                      name, inst, cyc, act, exp);
    endfunction

    function automatic void timeout(input string name, input int inst);
        n_total++;
        $display("FAIL %s inst%0d cycle %0d: no ack within bound", name, inst, cyc);
    endfunction

    // Runs at the negedge of cycle c: check cycle c, drive the read stub for
    // the edge ending c, then account for what that edge does.
    task automatic model_step(input int i);
        longint c;
        int ph;
        bit e0, e1;
        int w;
        c = cyc;
        if (m_ok[i]) begin
            if (mv[i] && !m_we[i] && c == m_ack[i]) m_rd[i][m_own[i]] = m_rv[i];
            ph = 0;
            if (mv[i] && c >= m_iss[i] && c <= m_ack[i])
                ph = (c == m_iss[i]) ? 1 : ((c == m_ack[i]) ? 3 : 2);
            chk("state",    i, 64'(st_a[i]), 64'(ph));
            chk("gnt",      i, 64'(gnt_a[i]), (ph != 0) ? 64'(1 << m_own[i]) : 64'(0));
            chk("gb_addr",  i, 64'(gba_a[i]), (ph == 1 || ph == 2) ? 64'(m_addr[i]) : 64'(0));
            chk("gb_dout",  i, 64'(gbo_a[i]), (ph == 1) ? 64'(m_wd[i]) : 64'(0));
            chk("gb_we",    i, 64'(gbwe_a[i]), 64'(ph == 1 && m_we[i]));
            chk("m0_ack",   i, 64'(ack_a[i][0]), 64'(ph == 3 && m_own[i] == 0));
            chk("m1_ack",   i, 64'(ack_a[i][1]), 64'(ph == 3 && m_own[i] == 1));
            chk("m0_rdata", i, 64'(rdata_a[i][0]), 64'(m_rd[i][0]));
            chk("m1_rdata", i, 64'(rdata_a[i][1]), 64'(m_rd[i][1]));
        end
        // the bus returns data only in the last cycle the address is held
        gbi_a[i] = (mv[i] && !m_we[i] && c == m_ack[i] - 1) ? m_rv[i] : $urandom;
        if (rst_a[i]) begin
            m_ok[i] = 1'b1;
            mv[i] = 1'b0;
            m_nidle[i] = c + 1;
            m_last[i] = 1;
            m_rd[i][0] = '0;
            m_rd[i][1] = '0;
        end else if (m_ok[i] && c >= m_nidle[i]) begin
            e0 = req_a[i][0] && !(mv[i] && m_own[i] == 0 && m_ack[i] == c - 1);
            e1 = req_a[i][1] && !(mv[i] && m_own[i] == 1 && m_ack[i] == c - 1);
            if (e0 || e1) begin
                w = (e0 && e1) ? ((m_last[i] == 0) ? 1 : 0) : (e1 ? 1 : 0);
                m_own[i]   = w;
                m_last[i]  = w;
                mv[i]      = 1'b1;
                m_iss[i]   = c + 1;
                m_we[i]    = we_a[i][w];
                m_addr[i]  = addr_a[i][w];
                m_wd[i]    = wdata_a[i][w];
                m_ack[i]   = m_we[i] ? c + 2 : c + 2 + rl_of(i);
                m_nidle[i] = m_ack[i] + 1;
                m_rv[i]    = use_42[i] ? 32'h42 : $urandom;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int m, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic w);
        addr_a[i][m]  = a;
        wdata_a[i][m] = d;
        we_a[i][m]    = w;
        req_a[i][m]   = 1'b1;
    endtask

    task automatic wait_ack(input int i, input int m, input bit scr, output longint ac);
        ac = -1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (scr && gnt_a[i][m]) begin
                addr_a[i][m]  = AW'($urandom);
                wdata_a[i][m] = $urandom;
                we_a[i][m]    = 1'($urandom);
            end
            @(negedge clk);
            if (ack_a[i][m]) begin
                ac = cyc;
                return;
            end
        end
        timeout("ack_wait", i);
    endtask

    task automatic wait_any_ack(input int i, output int who, output longint ac);
        who = -1;
        ac = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ack_a[i][0] || ack_a[i][1]) begin
                who = ack_a[i][1] ? 1 : 0;
                ac = cyc;
                return;
            end
        end
        timeout("any_ack", i);
    endtask

    task automatic rand_master(input int i, input int m, input int n_txn);
        longint ac;
        for (int t = 0; t < n_txn; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            set_req(i, m, AW'($urandom), $urandom, 1'($urandom));
            wait_ack(i, m, 1'b1, ac);
            tick();
            if ($urandom_range(0, 3) == 0) tick();
            req_a[i][m] = 1'b0;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    task automatic run_stimulus();
        longint c, ac, r, prev;
        int who, nwe, nack;
        longint ackc;

        // held through reset, then m0, m1, m0, m1 with a 3-cycle ack spacing
        set_req(0, 0, 12'h100, 32'h1111_0000, 1'b1);
        set_req(0, 1, 12'h200, 32'h2222_0000, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;
        r = cyc;
        prev = 0;
        for (int t = 0; t < 4; t++) begin
            wait_any_ack(0, who, ac);
            chk("rr_order", 0, 64'(who), 64'(t % 2));
            if (t == 0) chk("first_ack_cycle", 0, 64'(ac - r), 64'(2));
            else chk("ack_spacing", 0, 64'(ac - prev), 64'(3));
            prev = ac;
        end
        tick();
        req_a[0][0] = 1'b0;
        req_a[0][1] = 1'b0;
        repeat (2) tick();

        // single write, RL = 1
        set_req(0, 0, 12'h040, 32'h0000_00A5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("wr_gb_we",   0, 64'(gbwe_a[0]), 64'(1));
        chk("wr_gb_addr", 0, 64'(gba_a[0]), 64'(12'h040));
        chk("wr_gb_dout", 0, 64'(gbo_a[0]), 64'(32'hA5));
        @(negedge clk);
        chk("wr_ack",     0, 64'(ack_a[0][0]), 64'(1));
        chk("wr_we_off",  0, 64'(gbwe_a[0]), 64'(0));
        tick();
        req_a[0][0] = 1'b0;
        repeat (2) tick();

        // m0 keeps req one cycle past its ack: still exactly one transaction
        set_req(0, 0, 12'h123, 32'hDEAD_BEEF, 1'b1);
        ackc = -1;
        nwe = 0;
        nack = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (gbwe_a[0]) nwe++;
            if (ack_a[0][0]) begin
                nack++;
                ackc = cyc;
            end
            tick();
            if (ackc >= 0 && cyc == ackc + 2) req_a[0][0] = 1'b0;
        end
        req_a[0][0] = 1'b0;
        chk("mask_we_pulses", 0, 64'(nwe), 64'(1));
        chk("mask_acks",      0, 64'(nack), 64'(1));

        // single reads returning 0x42, RL = 1 and RL = 3
        for (int i = 0; i < 2; i++) begin
            use_42[i] = 1'b1;
            set_req(i, 1, 12'h000, 32'h0, 1'b0);
            c = cyc;
            wait_ack(i, 1, 1'b0, ac);
            chk("rd_ack_offset", i, 64'(ac - c), 64'((i == 0) ? 3 : 5));
            chk("rd_rdata",      i, 64'(rdata_a[i][1]), 64'(32'h42));
            tick();
            req_a[i][1] = 1'b0;
            use_42[i] = 1'b0;
            repeat (2) tick();
        end

        // reset in the second WAIT cycle of an RL = 4 read
        set_req(2, 0, 12'h0AB, 32'h0, 1'b0);
        repeat (3) tick();
        rst_a[2] = 1'b1;
        set_req(2, 1, 12'h0CD, 32'h0, 1'b0);
        tick();
        rst_a[2] = 1'b0;
        @(negedge clk);
        chk("rst_gnt",      2, 64'(gnt_a[2]), 64'(0));
        chk("rst_gb_addr",  2, 64'(gba_a[2]), 64'(0));
        chk("rst_gb_we",    2, 64'(gbwe_a[2]), 64'(0));
        chk("rst_m0_ack",   2, 64'(ack_a[2][0]), 64'(0));
        chk("rst_m0_rdata", 2, 64'(rdata_a[2][0]), 64'(0));
        chk("rst_state",    2, 64'(st_a[2]), 64'(0));
        @(negedge clk);
        chk("rst_first_tie", 2, 64'(gnt_a[2]), 64'(2'b01));
        wait_ack(2, 0, 1'b0, ac);
        tick();
        req_a[2][0] = 1'b0;
        wait_ack(2, 1, 1'b0, ac);
        tick();
        req_a[2][1] = 1'b0;
        repeat (2) tick();

        // req dropped before ack: the FSM still returns to IDLE
        set_req(2, 1, 12'h055, 32'h5555_5555, 1'b1);
        tick();
        req_a[2][1] = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("abandon_idle", 2, 64'(st_a[2]), 64'(0));
        tick();

        // random traffic on all six masters
        fork
            rand_master(0, 0, 170);
            rand_master(0, 1, 170);
            rand_master(1, 0, 170);
            rand_master(1, 1, 170);
            rand_master(2, 0, 170);
            rand_master(2, 1, 170);
        join
        repeat (10) tick();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_a[i]  = 1'b1;
            gbi_a[i]  = '0;
            m_ok[i]   = 1'b0;
            mv[i]     = 1'b0;
            m_iss[i]  = 0;
            m_ack[i]  = 0;
            m_nidle[i] = 0;
            m_own[i]  = 0;
            m_last[i] = 1;
            m_we[i]   = 1'b0;
            m_addr[i] = '0;
            m_wd[i]   = '0;
            m_rv[i]   = '0;
            use_42[i] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                req_a[i][m]   = 1'b0;
                addr_a[i][m]  = '0;
                wdata_a[i][m] = '0;
                we_a[i][m]    = 1'b0;
                m_rd[i][m]    = '0;
            end
        end
        fork
            begin
                run_stimulus();
                sim_done = 1'b1;
            end
            begin
                while (!sim_done) begin
                    @(negedge clk);
                    for (int i = 0; i < NI; i++) model_step(i);
                end
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
